// File: rtl/gf7_pkg.sv
// Shared GF(2^7) definitions for the Itoh-Tsujii inversion datapath:
// field constants, operand-select encodings, state encoding and the
// squaring / multiplication helpers (field polynomial x^7 + x + 1).
package gf7_pkg;

  localparam int          M         = 7;
  localparam logic [M-1:0] POLY     = 7'b0000011;
  localparam logic [2:0]  NUM_STEPS = 3'd5;
  localparam logic [2:0]  STEP_SAT  = 3'd7;

  typedef logic [M-1:0] gf7_t;

  // Operand A sources.
  typedef enum logic [1:0] {
    MUX1_A_IN = 2'b00,
    MUX1_BANK = 2'b01,
    MUX1_ACC  = 2'b10,
    MUX1_ZERO = 2'b11
  } mux1_sel_e;

  // Operand B sources.
  typedef enum logic [1:0] {
    MUX2_A_IN    = 2'b00,
    MUX2_CASCADE = 2'b01,
    MUX2_ACC     = 2'b10,
    MUX2_BANK    = 2'b11
  } mux2_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Fold a 13-bit carry-less product back into 7 bits. Top bits are
  // cleared from the highest down, so bits re-introduced by x^7 = x + 1
  // land below the current position and get folded later if needed.
  function automatic gf7_t gf7_reduce(input logic [2*M-2:0] p);
    logic [2*M-2:0] r;
    r = p;
    for (int i = 2*M-2; i >= M; i--) begin
      if (r[i]) begin
        r[i] = 1'b0;
        r    = r ^ ({{(M-1){1'b0}}, POLY} << (i-M));
      end
    end
    return r[M-1:0];
  endfunction

  // Squaring is linear over GF(2): spread bits to even positions, then
  // reduce. Synthesises to a fixed XOR map.
  function automatic gf7_t gf7_sq(input gf7_t a);
    logic [2*M-2:0] s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i] = a[i];
    return gf7_reduce(s);
  endfunction

  // Full field multiply: carry-less product followed by reduction.
  function automatic gf7_t gf7_mul(input gf7_t a, input gf7_t b);
    logic [2*M-2:0] p;
    p = '0;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ ({{(M-1){1'b0}}, a} << i);
    end
    return gf7_reduce(p);
  endfunction

endpackage

// File: rtl/gf7_mult.sv
// Combinational GF(2^M) multiplier: full MxM carry-less product followed
// by reduction with the low bits of the field polynomial.
module gf7_mult #(
  parameter int           M    = 7,
  parameter logic [M-1:0] POLY = 7'b0000011
) (
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_b,
  output logic [M-1:0] o_p
);

  logic [2*M-2:0] w_clmul;
  logic [2*M-2:0] w_red;

  // Carry-less partial-product accumulation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned (no latch).
    w_clmul = '0;
    for (int i = 0; i < M; i++) begin
      if (i_b[i]) w_clmul = w_clmul ^ ({{(M-1){1'b0}}, i_a} << i);
    end
  end

  // Reduction: fold bits 2M-2..M down using x^M = POLY.
  always_comb begin
    w_red = w_clmul;
    for (int i = 2*M-2; i >= M; i--) begin
      if (w_red[i]) begin
        w_red[i] = 1'b0;
        w_red    = w_red ^ ({{(M-1){1'b0}}, POLY} << (i-M));
      end
    end
  end

  assign o_p = w_red[M-1:0];

endmodule

// File: rtl/itoh_tsujii_datapath.sv
// Itoh-Tsujii inversion datapath for GF(2^7), driven step by step by the
// addition-chain sequencer. Holds the accumulator, the 4-entry beta bank
// and the squaring cascade; latches a validated inverse when the enable
// window closes after exactly NUM_STEPS steps, otherwise flags seq_err.
module itoh_tsujii_datapath #(
  parameter int           M    = 7,
  parameter logic [M-1:0] POLY = 7'b0000011
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [M-1:0] a_in,
  input  logic [1:0]   n_cascade,
  input  logic [1:0]   sel_read,
  input  logic [1:0]   sel_write,
  input  logic [1:0]   sel_mux1,
  input  logic [1:0]   sel_mux2,
  input  logic         en,
  output logic [M-1:0] inv_out,
  output logic         inv_valid,
  output logic         zero_flag,
  output logic         seq_err
);

  import gf7_pkg::*;

  state_e       r_state;
  logic [2:0]   r_step_cnt;
  logic [M-1:0] r_acc;
  logic [M-1:0] r_bank [0:3];
  logic [M-1:0] r_inv_out;
  logic         r_inv_valid;
  logic         r_zero_flag;
  logic         r_seq_err;

  logic [M-1:0] w_sq1;
  logic [M-1:0] w_sq2;
  logic [M-1:0] w_sq3;
  logic [M-1:0] w_casc;
  logic [M-1:0] w_bank_rd;
  logic [M-1:0] w_op_a;
  logic [M-1:0] w_op_b;
  logic [M-1:0] w_prod;
  logic         w_step;

  // Squaring cascade: acc, acc^2, acc^4, acc^8.
  assign w_sq1 = gf7_sq(r_acc);
  assign w_sq2 = gf7_sq(w_sq1);
  assign w_sq3 = gf7_sq(w_sq2);

  // Cascade tap select by the number of squarings requested.
  always_comb begin
    w_casc = r_acc;
    case (n_cascade)
      2'd1:    w_casc = w_sq1;
      2'd2:    w_casc = w_sq2;
      2'd3:    w_casc = w_sq3;
      default: w_casc = r_acc;
    endcase
  end

  // Bank read sees pre-edge contents, so a same-cycle write returns old data.
  assign w_bank_rd = r_bank[sel_read];

  // Operand A / operand B selection.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (sel_mux1)
      MUX1_A_IN: w_op_a = a_in;
      MUX1_BANK: w_op_a = w_bank_rd;
      MUX1_ACC:  w_op_a = r_acc;
      default:   w_op_a = '0;
    endcase
    case (sel_mux2)
      MUX2_A_IN:    w_op_b = a_in;
      MUX2_CASCADE: w_op_b = w_casc;
      MUX2_ACC:     w_op_b = r_acc;
      default:      w_op_b = w_bank_rd;
    endcase
  end

  gf7_mult #(
    .M    (M),
    .POLY (POLY)
  ) u_mult (
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_p (w_prod)
  );

  // A chain step happens on any enabled edge before the terminal state.
  assign w_step = en && (r_state != ST_DONE);

  // Control FSM, accumulator, beta bank and held result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_step_cnt  <= '0;
      r_acc       <= '0;
      // NOTE: the bank is reset explicitly because entry 0 must read as the constant 1 from the first step.
      r_bank[0]   <= 7'h01;
      for (int i = 1; i < 4; i++) r_bank[i] <= '0;
      r_inv_out   <= '0;
      r_inv_valid <= 1'b0;
      r_zero_flag <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so the bank captures the pre-edge acc while acc takes the new product.
      if (w_step) begin
        r_acc <= w_prod;
        if (r_step_cnt != STEP_SAT) r_step_cnt <= r_step_cnt + 3'd1;
        if (sel_write != 2'd0) r_bank[sel_write] <= r_acc;
      end
      case (r_state)
        ST_IDLE: begin
          if (en) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            r_state <= ST_DONE;
            if (r_step_cnt == NUM_STEPS) begin
              r_inv_out   <= r_acc;
              r_inv_valid <= 1'b1;
              r_zero_flag <= (r_acc == '0);
            end else begin
              r_seq_err   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign inv_out   = r_inv_out;
  assign inv_valid = r_inv_valid;
  assign zero_flag = r_zero_flag;
  assign seq_err   = r_seq_err;

endmodule
